uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 24 ++
 rtl/uart_tx_arb_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arb.sv | 122 ++++++++++++
 tb/tb_uart_tx_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arb_pkg
// Purpose : Shared state encoding and default parameter values for the UART
//           transmitter arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

    // Default configuration: four requesters, 16-byte maximum grant.
    localparam int C_DEF_NUM_REQ      = 4;
    localparam int C_DEF_REQ_ID_WIDTH = 2;
    localparam int C_DEF_MAX_PKT_LEN  = 16;
    localparam int C_DEF_CNT_WIDTH    = 4;

    // Arbiter ownership state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

endpackage : uart_tx_arb_pkg
`default_nettype wire

// File: rtl/uart_tx_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick. The search starts one position
//           after last_grant and walks upward with wrap; the first asserted
//           request wins.
// Ports   : req        - request vector, one bit per requester
//           last_grant - index of the most recent grant
//           winner     - index of the selected requester (0 when any = 0)
//           any        - at least one request is asserted
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N = C_DEF_NUM_REQ,
    parameter int W = C_DEF_REQ_ID_WIDTH
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] w_idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_idx  = '0;
        // Offset 1 first so the previous owner is considered last.
        for (int k = 1; k <= N; k++) begin
            w_idx = W'((int'(last_grant) + k) % N);
            if (!any && req[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arb
// Purpose : Shares one UART TX buffer between NUM_REQ byte-stream requesters.
//           A requester owns the transmitter from grant until its last byte or
//           until MAX_PKT_LEN bytes have been written, whichever comes first.
//           There is no internal data buffer: the owner's byte is steered
//           straight to the UART write port.
// Ports   : PCLK, PRESETN      - clock, asynchronous active-low reset
//           arb_en             - permits new grants (never aborts a packet)
//           req_valid/data/last- per-requester byte stream
//           req_ready          - per-requester byte accepted this cycle
//           tx_ready           - UART TX buffer not full
//           tx_data_reg_wr     - single-cycle write strobe to UART TX buffer
//           tx_data            - byte written to UART TX buffer
//           grant_id           - current owner, valid while busy = 1
//           busy               - a requester owns the transmitter
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = C_DEF_NUM_REQ,
    parameter int REQ_ID_WIDTH = C_DEF_REQ_ID_WIDTH,
    parameter int MAX_PKT_LEN  = C_DEF_MAX_PKT_LEN,
    parameter int CNT_WIDTH    = C_DEF_CNT_WIDTH
) (
    input  logic                    PCLK,
    input  logic                    PRESETN,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    tx_ready,
    output logic                    tx_data_reg_wr,
    output logic [7:0]              tx_data,
    output logic [REQ_ID_WIDTH-1:0] grant_id,
    output logic                    busy
);

    localparam logic [CNT_WIDTH-1:0]    C_CNT_LAST       = CNT_WIDTH'(MAX_PKT_LEN - 1);
    localparam logic [REQ_ID_WIDTH-1:0] C_LAST_GRANT_RST = REQ_ID_WIDTH'(NUM_REQ - 1);

    arb_state_t              r_state, w_state_nxt;
    logic [REQ_ID_WIDTH-1:0] r_grant_id, w_grant_id_nxt;
    logic [REQ_ID_WIDTH-1:0] r_last_grant, w_last_grant_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
    logic [REQ_ID_WIDTH-1:0] w_winner;
    logic                    w_any;
    logic                    w_xfer;
    logic                    w_release;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (REQ_ID_WIDTH)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any        (w_any)
    );

    // Only the owner's inputs are looked at; everyone else is ignored.
    assign w_xfer    = (r_state == ST_XFER) && req_valid[r_grant_id] && tx_ready;
    // A forced release at the length limit looks like an ordinary accept to
    // the requester; its remaining bytes simply re-arbitrate.
    assign w_release = w_xfer && (req_last[r_grant_id] || (r_cnt == C_CNT_LAST));

    assign tx_data_reg_wr = w_xfer;
    assign tx_data        = req_data[{r_grant_id, 3'b000} +: 8];
    assign grant_id       = r_grant_id;
    assign busy           = (r_state == ST_XFER);

    always_comb begin
        req_ready             = '0;
        req_ready[r_grant_id] = w_xfer;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (arb_en && w_any) begin
                    w_state_nxt      = ST_XFER;
                    w_grant_id_nxt   = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_cnt_nxt        = '0;
                end
            end
            ST_XFER: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                    if (w_release) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset leaves last_grant at the top index so requester 0 is searched first.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= C_LAST_GRANT_RST;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

endmodule : uart_tx_arb
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arb
// Purpose : Directed self-checking bench for uart_tx_arb (default parameters).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_ready;
    logic        tx_data_reg_wr;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arb dut (
        .PCLK           (PCLK),
        .PRESETN        (PRESETN),
        .arb_en         (arb_en),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_ready       (tx_ready),
        .tx_data_reg_wr (tx_data_reg_wr),
        .tx_data        (tx_data),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, ".busy"},  32'(busy),           32'd0);
        chk({tag, ".wr"},    32'(tx_data_reg_wr), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready),      32'd0);
    endtask

    task automatic chk_xfer(input string tag, input logic [1:0] g, input logic [7:0] d);
        #1;
        chk({tag, ".busy"},  32'(busy),           32'd1);
        chk({tag, ".gid"},   32'(grant_id),       32'(g));
        chk({tag, ".wr"},    32'(tx_data_reg_wr), 32'd1);
        chk({tag, ".data"},  32'(tx_data),        32'(d));
        chk({tag, ".ready"}, 32'(req_ready),      32'(4'b0001 << g));
    endtask

    task automatic chk_stall(input string tag, input logic [1:0] g);
        #1;
        chk({tag, ".busy"},  32'(busy),           32'd1);
        chk({tag, ".gid"},   32'(grant_id),       32'(g));
        chk({tag, ".wr"},    32'(tx_data_reg_wr), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready),      32'd0);
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]        = v;
        req_data[8*i +: 8]  = d;
        req_last[i]         = l;
    endtask

    // Requester i, packet k, byte b of the 2-byte-packet scenario.
    function automatic logic [7:0] pat(input int i, input int k, input int b);
        return 8'((i + 1) * 16 + k * 2 + b);
    endfunction

    int         ord [5]   = '{0, 1, 2, 3, 0};
    int         npk [4]   = '{2, 1, 1, 1};
    logic [7:0] exp2 [10] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31,
                              8'h40, 8'h41, 8'h12, 8'h13};
    int         pk  [4];

    initial begin
        PRESETN   = 1'b0;
        arb_en    = 1'b0;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge PCLK);
        #2;
        chk_idle("rst");
        chk("rst.gid", 32'(grant_id), 32'd0);
        PRESETN  = 1'b1;
        arb_en   = 1'b1;
        tx_ready = 1'b1;

        // Single one-byte packet from requester 0.
        drive(0, 1'b1, 8'h41, 1'b1);
        chk_idle("t1.pre");
        step();
        chk_xfer("t1.b0", 2'd0, 8'h41);
        step();
        chk_idle("t1.rel");
        drive(0, 1'b0, 8'h00, 1'b0);
        step();
        chk_idle("t1.quiet");

        // Fresh reset, then all four requesters with 2-byte packets.
        PRESETN = 1'b0;
        #1;
        PRESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pk[i] = 0;
            drive(i, 1'b1, pat(i, 0, 0), 1'b0);
        end
        for (int p = 0; p < 5; p++) begin
            int g;
            g = ord[p];
            step();
            chk_xfer($sformatf("t2.p%0d.b0", p), 2'(g), exp2[2*p]);
            step();
            drive(g, 1'b1, pat(g, pk[g], 1), 1'b1);
            chk_xfer($sformatf("t2.p%0d.b1", p), 2'(g), exp2[2*p+1]);
            step();
            pk[g]++;
            if (pk[g] < npk[g]) drive(g, 1'b1, pat(g, pk[g], 0), 1'b0);
            else                drive(g, 1'b0, 8'h00, 1'b0);
            chk_idle($sformatf("t2.p%0d.gap", p));
        end

        // Requester 2, 20 bytes: forced release after 16, then re-grant.
        drive(2, 1'b1, 8'h60, 1'b0);
        step();
        for (int b = 0; b < 16; b++) begin
            drive(2, 1'b1, 8'(32'h60 + b), 1'b0);
            chk_xfer($sformatf("t3.b%0d", b), 2'd2, 8'(32'h60 + b));
            step();
        end
        drive(2, 1'b1, 8'h70, 1'b0);
        chk_idle("t3.forced");
        step();
        for (int b = 16; b < 20; b++) begin
            drive(2, 1'b1, 8'(32'h60 + b), b == 19);
            chk_xfer($sformatf("t3.b%0d", b), 2'd2, 8'(32'h60 + b));
            step();
        end
        drive(2, 1'b0, 8'h00, 1'b0);
        chk_idle("t3.done");

        // Requester 1, 4 bytes, TX buffer full for 5 cycles after byte 0.
        drive(1, 1'b1, 8'hA0, 1'b0);
        step();
        chk_xfer("t4.b0", 2'd1, 8'hA0);
        step();
        drive(1, 1'b1, 8'hA1, 1'b0);
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk_stall($sformatf("t4.stall%0d", s), 2'd1);
            step();
        end
        tx_ready = 1'b1;
        chk_xfer("t4.b1", 2'd1, 8'hA1);
        step();
        drive(1, 1'b1, 8'hA2, 1'b0);
        chk_xfer("t4.b2", 2'd1, 8'hA2);
        step();
        drive(1, 1'b1, 8'hA3, 1'b1);
        chk_xfer("t4.b3", 2'd1, 8'hA3);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);
        chk_idle("t4.done");

        // arb_en dropped during requester 1's packet while requester 3 waits.
        drive(1, 1'b1, 8'hB0, 1'b0);
        step();
        chk_xfer("t5.b0", 2'd1, 8'hB0);
        arb_en = 1'b0;
        drive(3, 1'b1, 8'hC3, 1'b1);
        step();
        drive(1, 1'b1, 8'hB1, 1'b0);
        chk_xfer("t5.b1", 2'd1, 8'hB1);
        step();
        drive(1, 1'b1, 8'hB2, 1'b1);
        chk_xfer("t5.b2", 2'd1, 8'hB2);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);
        for (int s = 0; s < 3; s++) begin
            chk_idle($sformatf("t5.held%0d", s));
            step();
        end
        arb_en = 1'b1;
        chk_idle("t5.en");
        step();
        chk_xfer("t5.r3", 2'd3, 8'hC3);
        step();
        drive(3, 1'b0, 8'h00, 1'b0);
        chk_idle("t5.done");

        // Reset in the middle of requester 2's packet.
        drive(2, 1'b1, 8'hE0, 1'b0);
        step();
        chk_xfer("t6.b0", 2'd2, 8'hE0);
        step();
        drive(2, 1'b1, 8'hE1, 1'b0);
        drive(0, 1'b1, 8'hD0, 1'b1);
        chk_xfer("t6.b1", 2'd2, 8'hE1);
        PRESETN = 1'b0;
        chk_idle("t6.rst");
        chk("t6.rst.gid", 32'(grant_id), 32'd0);
        step();
        chk_idle("t6.rst2");
        PRESETN = 1'b1;
        step();
        chk_xfer("t6.r0", 2'd0, 8'hD0);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
        chk_idle("t6.done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_arb
`default_nettype wire
